// File: rtl/serial_pkg.sv
// Shared types and defaults for the LSB-first serial shift link.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  localparam int unsigned SER_WIDTH = 8;

endpackage

// File: rtl/serial_rx_8_bit_counter.sv
// Bit counter with synchronous clear, enable and terminal-count flag.
module bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc    = en && (count_q == CW'(WIDTH - 1));
  assign count = count_q;

  // Clear has priority over enable; wrap to zero on the terminal count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_rx_8.sv
// Serial-to-parallel receiver: Start-framed, LSB first, one-cycle Data_Valid per word.
module serial_rx_8
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic             Shift_In,
  output logic             Busy,
  output logic             Data_Valid,
  output logic [WIDTH-1:0] Data_Out,
  output logic [CW-1:0]    Bit_Count
);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  assign shifted = {Shift_In, sr_q[WIDTH-1:1]};
  // Start clears the word in every state and always beats a coincident bit.
  assign cnt_clr = Start;
  assign cnt_en  = (state_q == RECV) && Shift_En && !Start;

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (Bit_Count),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    data_out_d = data_out_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RECV;
          sr_d    = '0;
        end
      end
      RECV: begin
        if (Start) begin
          sr_d = '0;
        end else if (Shift_En) begin
          sr_d = shifted;
          if (cnt_tc) begin
            data_out_d = shifted;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RECV;
          sr_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the next-state decode, so they track state_q exactly.
    busy_d  = (state_d == RECV);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign Busy       = busy_q;
  assign Data_Valid = valid_q;
  assign Data_Out   = data_out_q;

endmodule

// File: doc/serial_rx_8.md
Name: serial_rx_8

Overview:
- Serial-to-parallel receiver: the receive end of the team's LSB-first serial shift link, where the transmitting register drives its LSB out on each shift-enable.
- Framed by a Start pulse; collects exactly WIDTH bits on qualified Shift_En cycles, then presents the assembled word with a one-cycle Data_Valid pulse.
- Sits between the serial link and downstream parallel logic (register file / ALU operand capture).

Parameters:
- WIDTH, 8, number of bits per word; must be >= 2.
- CW, $clog2(WIDTH+1), width of Bit_Count; derived, do not override.

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset. Acts immediately, independent of Clk.
- Start  input  1  begin or restart word reception.
- Shift_En  input  1  qualifies Shift_In as a valid bit this cycle.
- Shift_In  input  1  serial data, LSB of the word first.
- Busy  output  1  high while in RECV.
- Data_Valid  output  1  one-cycle pulse: Data_Out holds a new word.
- Data_Out  output  WIDTH  last completed word; held until the next completion.
- Bit_Count  output  CW  bits captured so far in the current word (0..WIDTH-1).

Behaviour:
- Reset: state=IDLE; shift register, Data_Out and Bit_Count = 0; Busy=0; Data_Valid=0.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - Busy=0.
  - Start=1 -> RECV; clear the shift register and Bit_Count.
  - Shift_En is ignored.
- RECV:
  - Busy=1.
  - On Shift_En=1: sr <= {Shift_In, sr[WIDTH-1:1]}; Bit_Count increments.
  - On Shift_En=0: hold sr and Bit_Count; no timeout.
  - When Bit_Count==WIDTH-1 and Shift_En=1: Data_Out <= {Shift_In, sr[WIDTH-1:1]}; Bit_Count <= 0; next state DONE.
- DONE:
  - Data_Valid=1 for exactly this one cycle; Busy=0.
  - Next state IDLE, or RECV if Start=1 (back-to-back words).
  - Shift_En is ignored unless Start restarts reception.
- Latency: Data_Valid rises in the cycle after the clock edge that samples the WIDTH-th bit. Data_Out is already updated in that cycle.
- Data_Valid and Busy are decoded from state (registered-state Moore outputs, glitch-free).
- Start in RECV: abort the current word; clear sr and Bit_Count; stay in RECV. Data_Out and Data_Valid are unaffected.
- Start and Shift_En in the same cycle: Start wins and the bit is discarded. This applies in every state.
- Reset mid-word: partial word lost; Data_Out clears to 0.
- Bit order: the first received bit lands in Data_Out[0] and the last in Data_Out[WIDTH-1]. This matches a transmitter that shifts right and drives its LSB.

Decomposition:
- Package serial_pkg:
  - typedef enum logic [1:0] rx_state_t {IDLE, RECV, DONE}
  - localparam default width SER_WIDTH=8, shared with the transmit register.
- One sub-module, bit_counter:
  - Parameterised CW-bit counter with clear, enable and terminal-count output (count==WIDTH-1 && en).
  - Async active-high reset.
- FSM, shift register and output register stay in serial_rx_8.

Test Plan:
- Reset, Start, then 8 consecutive Shift_En cycles with bits 1,0,1,0,0,1,0,1 -> Data_Valid high for one cycle, next cycle after the 8th bit; Data_Out=8'hA5; Busy low afterward.
- Same word with Shift_En deasserted for 3 cycles between bits 4 and 5 -> Bit_Count holds at 4; Data_Out=8'hA5 after completion; no early Data_Valid.
- Receive 8'h3C, then Start in the DONE cycle and receive 8'hC3 -> two Data_Valid pulses, Data_Out 8'h3C then 8'hC3; no idle cycle required between words.
- After 5 bits of 8'hFF, pulse Start with Shift_En=1, then send 8'h01 -> the bit in the Start cycle is discarded; Data_Out=8'h01; exactly one Data_Valid.
- Assert Reset asynchronously (between clock edges) at Bit_Count=6 -> Busy, Bit_Count and Data_Out go to 0 immediately; Shift_En pulses without Start produce no Data_Valid.
- Shift_En toggling in IDLE with no Start for 20 cycles -> Bit_Count stays 0; Data_Valid never asserts; Data_Out unchanged.
